// File: rtl/mem_arb_pkg.sv
// Types for the I/D unified memory-port arbiter.
package mem_arb_pkg;
    typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;
    typedef enum logic {OWN_I, OWN_D} arb_owner_t;
endpackage

// File: rtl/type_pkg.sv
// Shared core datatypes for addresses, data words and byte-lane enables.
package type_pkg;
    typedef logic [31:0] addr_t;
    typedef logic [31:0] data_t;
    typedef logic [3:0]  byte_en_t;
endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way combinational pick: req[0]=I, req[1]=D, one-hot grant.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       fixed_prio,
    output logic [1:0] grant
);
    always_comb begin
        grant = 2'b00;
        unique case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            // last_grant=0 means I went last, so D takes the tie
            2'b11:   grant = (fixed_prio || !last_grant) ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end
endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between I-fetch and data requesters.
// Optional stall counters are enabled with `define MEM_ARB_PERF_EN.
module mem_arbiter
    import type_pkg::*;
    import mem_arb_pkg::*;
#(
    parameter int unsigned FIXED_D_PRIO = 0,
    parameter int unsigned PERF_CNT_W   = 32
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     i_valid,
    input  addr_t    i_addr,
    output logic     i_ready,
    output data_t    i_rdata,
    input  logic     d_valid,
    input  addr_t    d_addr,
    input  data_t    d_wdata,
    input  byte_en_t d_byte_enable,
    output logic     d_ready,
    output data_t    d_rdata,
    output logic     mem_valid,
    output addr_t    mem_addr,
    output data_t    mem_wdata,
    output byte_en_t mem_byte_enable,
    input  logic     mem_ready,
    input  data_t    mem_rdata
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [PERF_CNT_W-1:0] perf_i_stall_cnt,
    output logic [PERF_CNT_W-1:0] perf_d_stall_cnt
`endif
);
    arb_state_t state_q, state_d;
    arb_owner_t owner_q, owner_d;
    arb_owner_t last_q, last_d;
    addr_t      addr_q, addr_d;
    data_t      wdata_q, wdata_d;
    byte_en_t   be_q, be_d;
    logic [1:0] grant;

    rr_arb2 u_pick (
        .req        ({d_valid, i_valid}),
        .last_grant (last_q == OWN_D),
        .fixed_prio (FIXED_D_PRIO != 0),
        .grant      (grant)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
            owner_q <= OWN_I;
            last_q  <= OWN_D;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (grant[1]) begin
                    state_d = ARB_BUSY;
                    owner_d = OWN_D;
                    last_d  = OWN_D;
                    addr_d  = d_addr;
                    wdata_d = d_wdata;
                    be_d    = d_byte_enable;
                end else if (grant[0]) begin
                    state_d = ARB_BUSY;
                    owner_d = OWN_I;
                    last_d  = OWN_I;
                    addr_d  = i_addr;
                    wdata_d = '0;
                    be_d    = '0;
                end
            end
            ARB_BUSY: begin
                if (mem_ready) state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        mem_valid       = (state_q == ARB_BUSY);
        mem_addr        = addr_q;
        mem_wdata       = wdata_q;
        mem_byte_enable = be_q;
        i_ready         = mem_valid && mem_ready && (owner_q == OWN_I);
        d_ready         = mem_valid && mem_ready && (owner_q == OWN_D);
        i_rdata         = mem_rdata;
        d_rdata         = mem_rdata;
    end

`ifdef MEM_ARB_PERF_EN
    logic [PERF_CNT_W-1:0] pi_q, pd_q;
    logic                  i_stall, d_stall;

    assign i_stall = i_valid && mem_valid && (owner_q == OWN_D);
    assign d_stall = d_valid && mem_valid && (owner_q == OWN_I);

    // Counters stick at all-ones rather than wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pi_q <= '0;
            pd_q <= '0;
        end else begin
            if (i_stall && !(&pi_q)) pi_q <= pi_q + PERF_CNT_W'(1);
            if (d_stall && !(&pd_q)) pd_q <= pd_q + PERF_CNT_W'(1);
        end
    end

    assign perf_i_stall_cnt = pi_q;
    assign perf_d_stall_cnt = pd_q;
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: scoreboard of expected grants
// plus hand-written reset, stray-ready and fixed-priority sequences.
module tb_mem_arbiter;
    typedef struct {
        logic        is_d;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } exp_t;

    typedef struct {
        logic        iv;
        logic [31:0] ia;
        logic        dv;
        logic [31:0] da;
        logic [31:0] dw;
        logic [3:0]  be;
        logic        d_first;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        i_valid, i_ready, d_valid, d_ready;
    logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata;
    logic [3:0]  d_be, mem_be;
    logic        mem_valid, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic        b_i_valid, b_i_ready, b_d_valid, b_d_ready;
    logic [31:0] b_i_addr, b_i_rdata, b_d_addr, b_d_wdata, b_d_rdata;
    logic [3:0]  b_d_be, b_mem_be;
    logic        b_mem_valid, b_mem_ready;
    logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

`ifdef MEM_ARB_PERF_EN
    logic [31:0] pi, pd;
    logic [2:0]  b_pi, b_pd;
`endif

    mem_arbiter #(.FIXED_D_PRIO(0), .PERF_CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_valid(i_valid), .i_addr(i_addr),
        .i_ready(i_ready), .i_rdata(i_rdata),
        .d_valid(d_valid), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_byte_enable(d_be), .d_ready(d_ready), .d_rdata(d_rdata),
        .mem_valid(mem_valid), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_byte_enable(mem_be),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
`ifdef MEM_ARB_PERF_EN
        , .perf_i_stall_cnt(pi), .perf_d_stall_cnt(pd)
`endif
    );

    mem_arbiter #(.FIXED_D_PRIO(1), .PERF_CNT_W(3)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .i_valid(b_i_valid), .i_addr(b_i_addr),
        .i_ready(b_i_ready), .i_rdata(b_i_rdata),
        .d_valid(b_d_valid), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
        .d_byte_enable(b_d_be), .d_ready(b_d_ready), .d_rdata(b_d_rdata),
        .mem_valid(b_mem_valid), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_byte_enable(b_mem_be),
        .mem_ready(b_mem_ready), .mem_rdata(b_mem_rdata)
`ifdef MEM_ARB_PERF_EN
        , .perf_i_stall_cnt(b_pi), .perf_d_stall_cnt(b_pd)
`endif
    );

    exp_t sb[$];
    int   total = 0;
    int   passed = 0;
    int   ip = 0, dp = 0, b_ip = 0, b_dp = 0;
    int   mem_lat = 2;
    logic stray = 1'b0;

    function automatic logic [31:0] mm(input logic [31:0] a);
        if (a == 32'h100) return 32'hDEADBEEF;
        return {a[15:0], a[31:16]} ^ 32'h3C3C_A5A5;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // memory model for the round-robin instance
    initial begin
        int cnt;
        cnt = 0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            if (mem_valid) cnt++;
            else cnt = 0;
            mem_ready = stray || (mem_valid && cnt == mem_lat);
            mem_rdata = mem_ready ? mm(mem_addr) : 32'h0;
        end
    end

    initial begin
        int cnt;
        cnt = 0;
        b_mem_ready = 1'b0;
        b_mem_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            if (b_mem_valid) cnt++;
            else cnt = 0;
            b_mem_ready = b_mem_valid && cnt == 2;
            b_mem_rdata = b_mem_ready ? mm(b_mem_addr) : 32'h0;
        end
    end

    // response monitor: pops the scoreboard on each ready pulse
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && (i_ready || d_ready)) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_ready", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("owner_i_ready", {31'd0, i_ready}, {31'd0, !e.is_d});
                    chk("owner_d_ready", {31'd0, d_ready}, {31'd0, e.is_d});
                    chk("mem_addr", mem_addr, e.addr);
                    chk("mem_wdata", mem_wdata, e.wdata);
                    chk("mem_be", {28'd0, mem_be}, {28'd0, e.be});
                    chk("rdata", e.is_d ? d_rdata : i_rdata, mm(e.addr));
                end
                if (i_ready) ip++;
                if (d_ready) dp++;
            end
            if (rst_n && b_i_ready) b_ip++;
            if (rst_n && b_d_ready) b_dp++;
        end
    end

    task automatic serve();
        logic ir, dr;
        for (int c = 0; c < 60 && (i_valid || d_valid); c++) begin
            @(negedge clk);
            ir = i_ready;
            dr = d_ready;
            @(posedge clk);
            #1;
            if (ir) i_valid = 1'b0;
            if (dr) d_valid = 1'b0;
        end
        if (i_valid || d_valid) begin
            chk("serve_timeout", 32'd1, 32'd0);
            i_valid = 1'b0;
            d_valid = 1'b0;
            sb.delete();
        end
    endtask

    task automatic apply(input vec_t v);
        exp_t ei, ed;
        int   ip0, dp0;
        ei = '{is_d: 1'b0, addr: v.ia, wdata: 32'h0, be: 4'h0};
        ed = '{is_d: 1'b1, addr: v.da, wdata: v.dw, be: v.be};
        @(posedge clk);
        #1;
        ip0 = ip;
        dp0 = dp;
        if (v.iv && v.dv) begin
            if (v.d_first) begin
                sb.push_back(ed);
                sb.push_back(ei);
            end else begin
                sb.push_back(ei);
                sb.push_back(ed);
            end
        end else if (v.iv) begin
            sb.push_back(ei);
        end else if (v.dv) begin
            sb.push_back(ed);
        end
        i_valid = v.iv;
        i_addr  = v.ia;
        d_valid = v.dv;
        d_addr  = v.da;
        d_wdata = v.dw;
        d_be    = v.be;
        serve();
        chk("i_pulses", ip - ip0, {31'd0, v.iv});
        chk("d_pulses", dp - dp0, {31'd0, v.dv});
        chk("sb_drained", sb.size(), 0);
    endtask

    vec_t tbl[7];

    initial begin
        int ip0, dp0, bad;
        logic dr;
        i_valid = 0; i_addr = 0; d_valid = 0; d_addr = 0;
        d_wdata = 0; d_be = 0;
        b_i_valid = 0; b_i_addr = 0; b_d_valid = 0; b_d_addr = 0;
        b_d_wdata = 0; b_d_be = 0;

        tbl[0] = '{iv:0, ia:0, dv:1, da:32'h2000, dw:32'h12345678,
                   be:4'b0011, d_first:0};
        tbl[1] = '{iv:1, ia:32'h300, dv:1, da:32'h400, dw:32'h0,
                   be:4'b0000, d_first:0};
        tbl[2] = '{iv:1, ia:32'h500, dv:1, da:32'h600, dw:32'hAABBCCDD,
                   be:4'b1111, d_first:0};
        tbl[3] = '{iv:0, ia:0, dv:1, da:32'h700, dw:32'h0,
                   be:4'b0000, d_first:0};
        tbl[4] = '{iv:1, ia:32'h800, dv:0, da:0, dw:0,
                   be:4'b0000, d_first:0};
        tbl[5] = '{iv:1, ia:32'h900, dv:1, da:32'hA04, dw:32'h55,
                   be:4'b1000, d_first:1};
        tbl[6] = '{iv:1, ia:32'hB00, dv:1, da:32'hC00, dw:32'h0,
                   be:4'b0000, d_first:1};

        repeat (2) @(negedge clk);
        chk("rst_mem_valid", {31'd0, mem_valid}, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_mem_be", {28'd0, mem_be}, 0);
        chk("rst_i_ready", {31'd0, i_ready}, 0);
        chk("rst_d_ready", {31'd0, d_ready}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

`ifdef MEM_ARB_PERF_EN
        chk("perf_rst_i", pi, 0);
        mem_lat = 5;
        @(posedge clk);
        #1;
        sb.push_back('{is_d: 1'b1, addr: 32'hA00, wdata: 32'h0, be: 4'h0});
        sb.push_back('{is_d: 1'b0, addr: 32'hB00, wdata: 32'h0, be: 4'h0});
        d_valid = 1; d_addr = 32'hA00; d_wdata = 0; d_be = 0;
        @(posedge clk);
        #1;
        i_valid = 1; i_addr = 32'hB00;
        serve();
        chk("perf_i_stall", pi, 5);
        chk("perf_d_stall", pd, 0);
        mem_lat = 2;
`endif

        // single I read with latency check
        @(posedge clk);
        #1;
        ip0 = ip;
        dp0 = dp;
        sb.push_back('{is_d: 1'b0, addr: 32'h100, wdata: 32'h0, be: 4'h0});
        i_valid = 1;
        i_addr  = 32'h100;
        @(negedge clk);
        chk("lat_before", {31'd0, mem_valid}, 0);
        @(negedge clk);
        chk("lat_after", {31'd0, mem_valid}, 1);
        chk("lat_addr", mem_addr, 32'h100);
        chk("lat_be", {28'd0, mem_be}, 0);
        serve();
        chk("iread_i_pulses", ip - ip0, 1);
        chk("iread_d_pulses", dp - dp0, 0);

        for (int k = 0; k < 7; k++) apply(tbl[k]);

        // stray mem_ready while idle
        @(posedge clk);
        #1;
        stray = 1'b1;
        @(negedge clk);
        chk("stray_i_ready", {31'd0, i_ready}, 0);
        chk("stray_d_ready", {31'd0, d_ready}, 0);
        chk("stray_mem_valid", {31'd0, mem_valid}, 0);
        @(posedge clk);
        #1;
        stray = 1'b0;
        @(negedge clk);
        chk("stray_idle", {31'd0, mem_valid}, 0);
        apply('{iv:1, ia:32'h1100, dv:1, da:32'h1200, dw:32'h0,
                be:4'b0000, d_first:1});

        // reset during an I transaction, after an I grant
        apply('{iv:1, ia:32'hE00, dv:0, da:0, dw:0, be:0, d_first:0});
        @(posedge clk);
        #1;
        i_valid = 1;
        i_addr  = 32'hF00;
        @(posedge clk);
        @(negedge clk);
        chk("mid_busy", {31'd0, mem_valid}, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, mem_valid}, 0);
        chk("mid_rst_addr", mem_addr, 0);
        chk("mid_rst_i_ready", {31'd0, i_ready}, 0);
`ifdef MEM_ARB_PERF_EN
        chk("mid_rst_perf", pi, 0);
`endif
        i_valid = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ip0 = ip;
        dp0 = dp;
        repeat (4) @(negedge clk);
        chk("post_rst_i", ip - ip0, 0);
        chk("post_rst_d", dp - dp0, 0);
        apply('{iv:1, ia:32'h1300, dv:1, da:32'h1400, dw:32'h77,
                be:4'b0100, d_first:0});
        apply('{iv:1, ia:32'h1500, dv:1, da:32'h1600, dw:32'h0,
                be:4'b0000, d_first:0});

        // fixed data priority instance, both held valid
        @(posedge clk);
        #1;
        ip0 = b_ip;
        dp0 = b_dp;
        bad = 0;
        b_i_valid = 1; b_i_addr = 32'hC00;
        b_d_valid = 1; b_d_addr = 32'hD00; b_d_wdata = 0; b_d_be = 0;
        repeat (30) begin
            @(negedge clk);
            if (b_mem_valid && b_mem_addr !== 32'hD00) bad++;
        end
        chk("prio_addr", bad, 0);
        chk("prio_no_i", b_ip - ip0, 0);
        chk("prio_d_ge3", {31'd0, (b_dp - dp0) >= 3}, 1);
`ifdef MEM_ARB_PERF_EN
        chk("perf_sat_i", {29'd0, b_pi}, 7);
        chk("perf_sat_d", {29'd0, b_pd}, 0);
`endif
        for (int c = 0; c < 20 && b_d_valid; c++) begin
            @(negedge clk);
            dr = b_d_ready;
            @(posedge clk);
            #1;
            if (dr) b_d_valid = 0;
        end
        for (int c = 0; c < 20 && b_i_valid; c++) begin
            @(negedge clk);
            dr = b_i_ready;
            @(posedge clk);
            #1;
            if (dr) b_i_valid = 0;
        end
        chk("prio_i_served", b_ip - ip0, 1);
        chk("final_sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
